// File: rtl/shake_squeeze.sv
// shake_squeeze
//   Squeeze-phase controller for SHAKE128/SHAKE256. It captures a completed
//   Keccak permutation state and streams its rate lanes as LANE_W-bit words.
//   When a block's rate lanes are used up, it requests another permutation.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle request to begin a squeeze (ignored while busy)
//   mode        0: SHAKE128 (21 rate lanes), 1: SHAKE256 (17 rate lanes)
//   out_words   number of words to emit (0 = request ignored)
//   perm_state  1600-bit permutation state, lane j = perm_state[j*64 +: 64]
//   perm_valid  perm_state holds a completed permutation
//   perm_req    one-cycle pulse asking for another permutation
//   out_data    current output word
//   out_valid   out_data valid
//   out_ready   downstream accept
//   out_last    final word of the squeeze
//   busy        controller not idle
//   done        one-cycle pulse after the final transfer
module shake_squeeze #(
   parameter int unsigned LANE_W = 64,
   parameter int unsigned CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [CNT_W-1:0]  out_words,
   input  logic [1599:0]     perm_state,
   input  logic              perm_valid,
   output logic              perm_req,
   output logic [LANE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // The largest rate is 21 lanes; capacity lanes are never emitted, so
   // only the rate portion of the state is kept.
   localparam int unsigned MAX_RATE = 21;
   localparam int unsigned BUF_W    = MAX_RATE * 64;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_PERM,
      STREAM
   } state_t;

   state_t            state, state_nxt;
   logic              armed, armed_nxt;
   logic [4:0]        lane_idx, lane_nxt;
   logic [CNT_W-1:0]  remaining, rem_nxt;
   logic              mode_r, mode_nxt;
   logic [BUF_W-1:0]  buffer, src;
   logic              capture;
   logic              xfer, last_xfer, bound_xfer;
   logic [4:0]        rate_m1;
   logic [LANE_W-1:0] data_nxt;
   logic              unused_capacity;

   assign unused_capacity = ^perm_state[1599:BUF_W];

   always_comb begin
      state_nxt  = state;
      armed_nxt  = armed;
      lane_nxt   = lane_idx;
      rem_nxt    = remaining;
      mode_nxt   = mode_r;
      capture    = 1'b0;
      last_xfer  = 1'b0;
      bound_xfer = 1'b0;
      rate_m1    = mode_r ? 5'd16 : 5'd20;
      xfer       = out_valid & out_ready;

      case (state)
         IDLE: begin
            if (start && out_words != '0) begin
               mode_nxt  = mode;
               rem_nxt   = out_words;
               armed_nxt = 1'b1;
               lane_nxt  = '0;
               state_nxt = WAIT_PERM;
            end
         end
         WAIT_PERM: begin
            // armed stays clear after a perm_req until perm_valid has been
            // seen low, so a stale perm_valid is never mistaken for the new
            // permutation.
            if (!perm_valid) begin
               armed_nxt = 1'b1;
            end else if (armed) begin
               capture   = 1'b1;
               lane_nxt  = '0;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (xfer) begin
               rem_nxt  = remaining - CNT_W'(1);
               lane_nxt = lane_idx + 5'd1;
               // The final word takes priority over the rate boundary.
               if (remaining == CNT_W'(1)) begin
                  last_xfer = 1'b1;
                  state_nxt = IDLE;
               end else if (lane_idx == rate_m1) begin
                  bound_xfer = 1'b1;
                  armed_nxt  = 1'b0;
                  state_nxt  = WAIT_PERM;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Output word is registered, so it is selected from the lane the
      // controller will point at next, using the freshly captured state on
      // a capture cycle.
      src      = capture ? perm_state[BUF_W-1:0] : buffer;
      data_nxt = '0;
      for (int unsigned j = 0; j < MAX_RATE; j++) begin
         if (lane_nxt == 5'(j)) begin
            data_nxt = src[j*64 +: LANE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         armed     <= 1'b0;
         lane_idx  <= '0;
         remaining <= '0;
         mode_r    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         perm_req  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         armed     <= armed_nxt;
         lane_idx  <= lane_nxt;
         remaining <= rem_nxt;
         mode_r    <= mode_nxt;
         if (capture) begin
            buffer <= perm_state[BUF_W-1:0];
         end
         out_data  <= data_nxt;
         out_valid <= (state_nxt == STREAM);
         out_last  <= (state_nxt == STREAM) && (rem_nxt == CNT_W'(1));
         perm_req  <= bound_xfer;
         busy      <= (state_nxt != IDLE);
         done      <= last_xfer;
      end
   end

endmodule

// File: tb/tb_shake_squeeze.sv
module tb_shake_squeeze;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mode;
   logic [10:0]   out_words;
   logic [1599:0] perm_state;
   logic          perm_valid;
   logic          perm_req;
   logic [63:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;

   shake_squeeze #(.LANE_W(64), .CNT_W(11)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .out_words  (out_words),
      .perm_state (perm_state),
      .perm_valid (perm_valid),
      .perm_req   (perm_req),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1599:0] lanes(input int unsigned base);
      logic [1599:0] r;
      r = '0;
      for (int unsigned j = 0; j < 25; j++) r[j*64 +: 64] = 64'(base + j);
      return r;
   endfunction

   task automatic test_reset();
      rst = 1; start = 1; perm_valid = 1; mode = 0; out_words = 11'd3; out_ready = 1;
      perm_state = lanes(0);
      tick();
      n_checks++;
      if ({out_valid, out_last, perm_req, busy, done} !== 5'b0) begin
         $display("FAIL reset_ctrl: got v/l/pr/b/d=%b expected 00000",
                  {out_valid, out_last, perm_req, busy, done});
         n_fail++;
      end
      n_checks++;
      if (out_data !== 64'd0) begin
         $display("FAIL reset_data: got %0d expected 0", out_data);
         n_fail++;
      end
      rst = 0; start = 0;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_release_busy: got %b expected 0", busy);
         n_fail++;
      end
   endtask

   task automatic test_shake128_short();
      perm_state = lanes(0); perm_valid = 1; out_ready = 1;
      mode = 0; out_words = 11'd3; start = 1;
      tick();
      start = 0;
      n_checks++;
      if ({busy, out_valid} !== 2'b10) begin
         $display("FAIL s128_wait: got busy/valid=%b expected 10", {busy, out_valid});
         n_fail++;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({out_valid, out_last, perm_req} !== {1'b1, (i == 2), 1'b0} || out_data !== 64'(i)) begin
            $display("FAIL s128_word%0d: got v/l/pr=%b data=%0d expected %b data=%0d",
                     i, {out_valid, out_last, perm_req}, out_data, {1'b1, (i == 2), 1'b0}, i);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if ({out_valid, done, busy, perm_req} !== 4'b0100) begin
         $display("FAIL s128_done: got v/d/b/pr=%b expected 0100", {out_valid, done, busy, perm_req});
         n_fail++;
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         $display("FAIL s128_done_pulse: got %b expected 0", done);
         n_fail++;
      end
   endtask

   task automatic test_shake256_block();
      perm_state = lanes(0); perm_valid = 1; out_ready = 1;
      mode = 1; out_words = 11'd20; start = 1;
      tick();
      start = 0;
      tick();
      for (int i = 0; i < 17; i++) begin
         n_checks++;
         if ({out_valid, out_last, perm_req} !== 3'b100 || out_data !== 64'(i)) begin
            $display("FAIL s256_blk0_word%0d: got v/l/pr=%b data=%0d expected 100 data=%0d",
                     i, {out_valid, out_last, perm_req}, out_data, i);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if ({perm_req, out_valid, busy} !== 3'b101) begin
         $display("FAIL s256_perm_req: got pr/v/b=%b expected 101", {perm_req, out_valid, busy});
         n_fail++;
      end
      tick();
      n_checks++;
      if ({perm_req, out_valid} !== 2'b00) begin
         $display("FAIL s256_stale1: got pr/v=%b expected 00", {perm_req, out_valid});
         n_fail++;
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL s256_stale2: got valid=%b expected 0", out_valid);
         n_fail++;
      end
      perm_valid = 0;
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL s256_low: got v/b=%b expected 01", {out_valid, busy});
         n_fail++;
      end
      perm_state = lanes(100); perm_valid = 1;
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({out_valid, out_last, perm_req} !== {1'b1, (i == 2), 1'b0} || out_data !== 64'(100 + i)) begin
            $display("FAIL s256_blk1_word%0d: got v/l/pr=%b data=%0d expected %b data=%0d",
                     i, {out_valid, out_last, perm_req}, out_data, {1'b1, (i == 2), 1'b0}, 100 + i);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if ({out_valid, done, perm_req} !== 3'b010) begin
         $display("FAIL s256_done: got v/d/pr=%b expected 010", {out_valid, done, perm_req});
         n_fail++;
      end
   endtask

   task automatic test_backpressure();
      logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      int idx = 0;
      perm_state = lanes(50); perm_valid = 1; out_ready = 1;
      mode = 0; out_words = 11'd5; start = 1;
      tick();
      start = 0;
      tick();
      for (int k = 0; k < 8; k++) begin
         out_ready = pat[k];
         n_checks++;
         if ({out_valid, out_last} !== {1'b1, (idx == 4)} || out_data !== 64'(50 + idx)) begin
            $display("FAIL bp_cycle%0d: got v/l=%b data=%0d expected %b data=%0d",
                     k, {out_valid, out_last}, out_data, {1'b1, (idx == 4)}, 50 + idx);
            n_fail++;
         end
         if (pat[k]) idx++;
         tick();
      end
      out_ready = 1;
      n_checks++;
      if ({out_valid, done} !== 2'b01) begin
         $display("FAIL bp_done: got v/d=%b expected 01", {out_valid, done});
         n_fail++;
      end
   endtask

   task automatic test_ignored_starts();
      out_words = 11'd0; mode = 0; start = 1;
      tick();
      start = 0;
      n_checks++;
      if ({busy, out_valid} !== 2'b00) begin
         $display("FAIL zero_start_busy: got b/v=%b expected 00", {busy, out_valid});
         n_fail++;
      end
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         $display("FAIL zero_start_busy2: got %b expected 0", busy);
         n_fail++;
      end
      perm_state = lanes(0); perm_valid = 1; out_ready = 1;
      mode = 0; out_words = 11'd4; start = 1;
      tick();
      start = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            start = 1; mode = 1; out_words = 11'd1;
         end else begin
            start = 0;
         end
         n_checks++;
         if ({out_valid, out_last} !== {1'b1, (i == 3)} || out_data !== 64'(i)) begin
            $display("FAIL midstart_word%0d: got v/l=%b data=%0d expected %b data=%0d",
                     i, {out_valid, out_last}, out_data, {1'b1, (i == 3)}, i);
            n_fail++;
         end
         tick();
      end
      start = 0;
      n_checks++;
      if ({out_valid, done} !== 2'b01) begin
         $display("FAIL midstart_done: got v/d=%b expected 01", {out_valid, done});
         n_fail++;
      end
      tick();
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL midstart_idle: got b/d=%b expected 00", {busy, done});
         n_fail++;
      end
   endtask

   task automatic test_final_at_boundary();
      perm_state = lanes(0); perm_valid = 1; out_ready = 1;
      mode = 0; out_words = 11'd21; start = 1;
      tick();
      start = 0;
      tick();
      for (int i = 0; i < 21; i++) begin
         n_checks++;
         if ({out_valid, out_last} !== {1'b1, (i == 20)} || out_data !== 64'(i)) begin
            $display("FAIL boundary_word%0d: got v/l=%b data=%0d expected %b data=%0d",
                     i, {out_valid, out_last}, out_data, {1'b1, (i == 20)}, i);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if ({done, perm_req, busy} !== 3'b100) begin
         $display("FAIL boundary_done: got d/pr/b=%b expected 100", {done, perm_req, busy});
         n_fail++;
      end
   endtask

   task automatic test_reset_midstream();
      perm_state = lanes(0); perm_valid = 1; out_ready = 1;
      mode = 0; out_words = 11'd10; start = 1;
      tick();
      start = 0;
      tick();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 64'(i)) begin
            $display("FAIL rstmid_word%0d: got v=%b data=%0d expected 1 data=%0d", i, out_valid, out_data, i);
            n_fail++;
         end
         tick();
      end
      rst = 1;
      tick();
      rst = 0;
      n_checks++;
      if ({busy, out_valid, done, out_last} !== 4'b0000 || out_data !== 64'd0) begin
         $display("FAIL rstmid_abort: got b/v/d/l=%b data=%0d expected 0000 data=0",
                  {busy, out_valid, done, out_last}, out_data);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL rstmid_no_done: got b/d=%b expected 00", {busy, done});
         n_fail++;
      end
      out_words = 11'd2; start = 1;
      tick();
      start = 0;
      tick();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({out_valid, out_last} !== {1'b1, (i == 1)} || out_data !== 64'(i)) begin
            $display("FAIL rstmid_restart%0d: got v/l=%b data=%0d expected %b data=%0d",
                     i, {out_valid, out_last}, out_data, {1'b1, (i == 1)}, i);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if (done !== 1'b1) begin
         $display("FAIL rstmid_restart_done: got %b expected 1", done);
         n_fail++;
      end
   endtask

   initial begin
      rst = 1; start = 0; mode = 0; out_words = '0;
      perm_state = '0; perm_valid = 0; out_ready = 0;
      test_reset();
      test_shake128_short();
      test_shake256_block();
      test_backpressure();
      test_ignored_starts();
      test_final_at_boundary();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
